// File: rtl/tpm_fifo_pkg.sv
// tpm_fifo_pkg: shared state encoding, register map and status bit positions for the TPM FIFO backend
package tpm_fifo_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READY,
        ST_RECEPTION,
        ST_EXECUTION,
        ST_COMPLETION
    } tpm_state_e;
    localparam logic [11:0] REG_ACCESS    = 12'h000;
    localparam logic [11:0] REG_STS       = 12'h018;
    localparam logic [11:0] REG_DATA_FIFO = 12'h024;
    localparam logic [11:0] REG_DID_VID   = 12'hF00;
    localparam logic [11:0] REG_RID       = 12'hF04;
    localparam int STS_VALID      = 7;
    localparam int STS_CMD_READY  = 6;
    localparam int STS_GO         = 5;
    localparam int STS_DATA_AVAIL = 4;
    localparam int STS_EXPECT     = 3;
    localparam int ACC_REG_VALID  = 7;
    localparam int ACC_ACTIVE     = 5;
    localparam int ACC_REQUEST    = 1;
endpackage

// File: rtl/tpm_byte_fifo.sv
// tpm_byte_fifo: power-of-two byte FIFO with occupancy count and synchronous flush
module tpm_byte_fifo #(
    parameter int DEPTH = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [7:0]             wdata_i,
    input  logic                   pop_i,
    output logic [7:0]             rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic do_push, do_pop;
    assign full_o  = count_o[AW];
    assign empty_o = count_o == '0;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem[rp_q];
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_o <= '0;
        end else if (flush_i) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_o <= '0;
        end else begin
            wp_q    <= do_push ? wp_q + 1'b1 : wp_q;
            rp_q    <= do_pop ? rp_q + 1'b1 : rp_q;
            count_o <= count_o + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wp_q] <= wdata_i;
    end
endmodule

// File: rtl/tpm_fifo_backend.sv
// tpm_fifo_backend: locality-0 TPM FIFO register backend behind spi_periph; TPM_ACCESS_ARB_EN enables locality arbitration
module tpm_fifo_backend
    import tpm_fifo_pkg::*;
#(
    parameter int          DEPTH = 64,
    parameter logic [15:0] VID   = 16'h1AF4,
    parameter logic [15:0] DID   = 16'h0001,
    parameter logic [7:0]  RID   = 8'h00
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        spi_cs_n_i,
    input  logic [15:0] addr_i,
    input  logic [7:0]  wdata_i,
    input  logic        data_wr_i,
    output logic        wr_done_o,
    input  logic        data_req_i,
    output logic [7:0]  rdata_o,
    output logic        data_rd_o,
    output logic [7:0]  cmd_data_o,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output logic        cmd_go_o,
    input  logic [7:0]  rsp_data_i,
    input  logic        rsp_valid_i,
    output logic        rsp_ready_o,
    input  logic        rsp_done_i
);
    localparam int CW = $clog2(DEPTH) + 1;
    tpm_state_e state_q, state_d;
    logic [2:0] s1_q, s2_q, s3_q;
    logic wr_rise, req_rise, req_fall, cs_rise;
    logic [1:0] off_q;
    logic [15:0] eff, burst;
    logic [11:0] a;
    logic mapped, is_access, is_sts, is_fifo, is_didvid, is_rid;
    logic loc, sts_wr, fifo_wr, fifo_rd_ok, flush, go;
    logic [7:0] sts0, sts_byte, rd_byte, cmd_head, rsp_head;
    logic [31:0] id_word;
    logic [CW-1:0] cmd_count, rsp_count;
    logic cmd_full, cmd_empty, rsp_full, rsp_empty;
    // {cs_n, req, wr} through two sync flops plus one history flop for edge detection
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_q <= 3'b100;
            s2_q <= 3'b100;
            s3_q <= 3'b100;
        end else begin
            s1_q <= {spi_cs_n_i, data_req_i, data_wr_i};
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end
    assign wr_rise  = s2_q[0] & ~s3_q[0];
    assign req_rise = s2_q[1] & ~s3_q[1];
    assign req_fall = ~s2_q[1] & s3_q[1];
    assign cs_rise  = s2_q[2] & ~s3_q[2];
    assign eff       = addr_i + {14'd0, off_q};
    assign a         = eff[11:0];
    assign mapped    = addr_i[15:12] == 4'd0 && eff[15:12] == 4'd0;
    assign is_access = mapped && a == REG_ACCESS;
    assign is_sts    = mapped && a[11:2] == REG_STS[11:2];
    assign is_fifo   = mapped && a[11:2] == REG_DATA_FIFO[11:2];
    assign is_didvid = mapped && a[11:2] == REG_DID_VID[11:2];
    assign is_rid    = mapped && a == REG_RID;
`ifdef TPM_ACCESS_ARB_EN
    logic loc_q;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) loc_q <= 1'b0;
        else if (wr_rise && is_access) loc_q <= wdata_i[ACC_REQUEST] ? 1'b1 : wdata_i[ACC_ACTIVE] ? 1'b0 : loc_q;
    end
    assign loc = loc_q;
`else
    assign loc = 1'b1;
`endif
    assign sts_wr     = wr_rise && is_sts && a[1:0] == 2'd0 && loc;
    assign fifo_wr    = wr_rise && is_fifo && loc && (state_q == ST_READY || state_q == ST_RECEPTION);
    assign fifo_rd_ok = state_q == ST_COMPLETION && !rsp_empty;
    assign sts0       = {1'b1, state_q == ST_READY, 1'b0, fifo_rd_ok,
                         state_q == ST_READY || state_q == ST_RECEPTION, 3'b000};
    assign burst      = (state_q == ST_READY || state_q == ST_RECEPTION) ? 16'(DEPTH) - 16'(cmd_count) :
                        state_q == ST_COMPLETION ? 16'(rsp_count) : 16'd0;
    assign sts_byte   = !loc ? 8'hFF : a[1:0] == 2'd0 ? sts0 : a[1:0] == 2'd1 ? burst[7:0] :
                        a[1:0] == 2'd2 ? burst[15:8] : 8'h00;
    assign id_word    = {DID, VID};
    assign rd_byte    = is_access ? {1'b1, 1'b0, loc, 5'b0} : is_sts ? sts_byte :
                        is_fifo ? (fifo_rd_ok ? rsp_head : 8'hFF) :
                        is_didvid ? id_word[{a[1:0], 3'b000} +: 8] : is_rid ? RID : 8'hFF;
    always_comb begin
        state_d = state_q;
        flush   = 1'b0;
        go      = 1'b0;
        if (sts_wr && wdata_i[STS_CMD_READY] && state_q != ST_EXECUTION) begin
            state_d = ST_READY;
            flush   = 1'b1;
        end else if (sts_wr && wdata_i[STS_GO] && state_q == ST_RECEPTION) begin
            state_d = ST_EXECUTION;
            go      = 1'b1;
        end else if (fifo_wr) begin
            state_d = ST_RECEPTION;
        end else if (state_q == ST_EXECUTION && rsp_done_i) begin
            state_d = ST_COMPLETION;
        end
    end
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= ST_IDLE;
        else state_q <= state_d;
    end
    // a cs rise coinciding with a request fall still lets the pop happen; only the offset clears
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            off_q     <= 2'd0;
            rdata_o   <= 8'hFF;
            data_rd_o <= 1'b0;
            wr_done_o <= 1'b0;
            cmd_go_o  <= 1'b0;
        end else begin
            off_q     <= cs_rise ? 2'd0 : (wr_rise || req_fall) ? off_q + 2'd1 : off_q;
            rdata_o   <= req_rise ? rd_byte : rdata_o;
            data_rd_o <= req_rise ? 1'b1 : req_fall ? 1'b0 : data_rd_o;
            wr_done_o <= wr_rise;
            cmd_go_o  <= go;
        end
    end
    assign cmd_valid_o = state_q == ST_EXECUTION && !cmd_empty;
    assign cmd_data_o  = cmd_head;
    assign rsp_ready_o = state_q == ST_EXECUTION && !rsp_full;
    tpm_byte_fifo #(.DEPTH(DEPTH)) u_cmd_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (flush),
        .push_i  (fifo_wr && !cmd_full),
        .wdata_i (wdata_i),
        .pop_i   (cmd_valid_o && cmd_ready_i),
        .rdata_o (cmd_head),
        .count_o (cmd_count),
        .full_o  (cmd_full),
        .empty_o (cmd_empty)
    );
    tpm_byte_fifo #(.DEPTH(DEPTH)) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (flush),
        .push_i  (rsp_valid_i && rsp_ready_o),
        .wdata_i (rsp_data_i),
        .pop_i   (req_fall && is_fifo && fifo_rd_ok),
        .rdata_o (rsp_head),
        .count_o (rsp_count),
        .full_o  (rsp_full),
        .empty_o (rsp_empty)
    );
endmodule

// File: tb/tb_tpm_fifo_backend.sv
// tb_tpm_fifo_backend: directed/randomized bench against a queue-based register model
module tb_tpm_fifo_backend;
    localparam int          DEPTH = 64;
    localparam logic [15:0] VID   = 16'h1AF4;
    localparam logic [15:0] DID   = 16'h0001;
    localparam logic [7:0]  RID   = 8'h00;
    logic clk_i = 1'b0, rst_n_i = 1'b0, spi_cs_n_i = 1'b1;
    logic [15:0] addr_i = '0;
    logic [7:0] wdata_i = '0, rdata_o, cmd_data_o, rsp_data_i = '0;
    logic data_wr_i = 1'b0, wr_done_o, data_req_i = 1'b0, data_rd_o;
    logic cmd_valid_o, cmd_ready_i = 1'b0, cmd_go_o;
    logic rsp_valid_i = 1'b0, rsp_ready_o, rsp_done_i = 1'b0;
    always #5 clk_i = ~clk_i;
    tpm_fifo_backend #(.DEPTH(DEPTH), .VID(VID), .DID(DID), .RID(RID)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .spi_cs_n_i(spi_cs_n_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .data_wr_i(data_wr_i), .wr_done_o(wr_done_o),
        .data_req_i(data_req_i), .rdata_o(rdata_o), .data_rd_o(data_rd_o),
        .cmd_data_o(cmd_data_o), .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
        .cmd_go_o(cmd_go_o), .rsp_data_i(rsp_data_i), .rsp_valid_i(rsp_valid_i),
        .rsp_ready_o(rsp_ready_o), .rsp_done_i(rsp_done_i)
    );
    int checks = 0, errors = 0, go_seen = 0, exp_go = 0;
    typedef enum {M_IDLE, M_READY, M_RECEP, M_EXEC, M_COMPL} mst_e;
    mst_e ms = M_IDLE;
    logic [7:0] cmd_m[$], rsp_m[$], exp_cmd[$], got_cmd[$];
`ifdef TPM_ACCESS_ARB_EN
    bit loc_m = 1'b0;
`else
    bit loc_m = 1'b1;
`endif
    always @(negedge clk_i) begin
        if (cmd_valid_o && cmd_ready_i) got_cmd.push_back(cmd_data_o);
        if (cmd_go_o) go_seen++;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic int m_burst();
        if (ms == M_READY || ms == M_RECEP) return DEPTH - cmd_m.size();
        if (ms == M_COMPL) return rsp_m.size();
        return 0;
    endfunction
    function automatic logic [7:0] m_sts0();
        int v = 8'h80;
        if (ms == M_READY) v += 8'h40;
        if (ms == M_COMPL && rsp_m.size() > 0) v += 8'h10;
        if (ms == M_READY || ms == M_RECEP) v += 8'h08;
        return 8'(v);
    endfunction
    task automatic m_read(input logic [15:0] base, input logic [15:0] ea, output logic [7:0] v);
        logic [31:0] id = {DID, VID};
        v = 8'hFF;
        if (base[15:12] != 0 || ea[15:12] != 0) return;
        if (ea == 16'h000) v = loc_m ? 8'hA0 : 8'h80;
        else if (ea >= 16'h018 && ea <= 16'h01B) begin
            if (!loc_m) v = 8'hFF;
            else if (ea == 16'h018) v = m_sts0();
            else if (ea == 16'h019) v = 8'(m_burst() % 256);
            else if (ea == 16'h01A) v = 8'(m_burst() / 256);
            else v = 8'h00;
        end else if (ea >= 16'h024 && ea <= 16'h027) begin
            if (ms == M_COMPL && rsp_m.size() > 0) v = rsp_m.pop_front();
        end else if (ea >= 16'hF00 && ea <= 16'hF03) v = 8'(id >> (8 * (ea - 16'hF00)));
        else if (ea == 16'hF04) v = RID;
    endtask
    task automatic m_write(input logic [15:0] base, input logic [15:0] ea, input logic [7:0] d);
        if (base[15:12] != 0 || ea[15:12] != 0) return;
        if (ea == 16'h000) begin
`ifdef TPM_ACCESS_ARB_EN
            if (d[1]) loc_m = 1'b1;
            else if (d[5]) loc_m = 1'b0;
`endif
        end else if (ea == 16'h018 && loc_m) begin
            if (d[6] && ms != M_EXEC) begin
                ms = M_READY;
                cmd_m.delete();
                rsp_m.delete();
            end else if (d[5] && ms == M_RECEP) begin
                ms = M_EXEC;
                exp_cmd = cmd_m;
                cmd_m.delete();
                exp_go++;
            end
        end else if (ea >= 16'h024 && ea <= 16'h027 && loc_m && (ms == M_READY || ms == M_RECEP)) begin
            if (cmd_m.size() < DEPTH) cmd_m.push_back(d);
            ms = M_RECEP;
        end
    endtask
    task automatic spi_begin();
        @(negedge clk_i);
        spi_cs_n_i = 1'b0;
        repeat (3) @(negedge clk_i);
    endtask
    task automatic spi_end();
        spi_cs_n_i = 1'b1;
        repeat (6) @(negedge clk_i);
    endtask
    task automatic wr_byte(input logic [15:0] base, input logic [1:0] off, input logic [7:0] d);
        int lat = 0, pulses = 0;
        addr_i = base;
        wdata_i = d;
        data_wr_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk_i);
            if (wr_done_o) begin
                pulses++;
                if (lat == 0) lat = i;
            end
        end
        data_wr_i = 1'b0;
        repeat (6) @(negedge clk_i);
        check($sformatf("wr_done latency @%h", base), lat, 3);
        check($sformatf("wr_done pulses @%h", base), pulses, 1);
        m_write(base, base + 16'(off), d);
    endtask
    task automatic rd_byte(input logic [15:0] base, input logic [1:0] off);
        int lat = 0;
        logic [7:0] exp, got;
        addr_i = base;
        data_req_i = 1'b1;
        for (int i = 1; i <= 12 && lat == 0; i++) begin
            @(negedge clk_i);
            if (data_rd_o) lat = i;
        end
        got = rdata_o;
        m_read(base, base + 16'(off), exp);
        check($sformatf("data_rd latency @%h+%0d", base, off), lat, 3);
        check($sformatf("rdata @%h+%0d", base, off), got, exp);
        data_req_i = 1'b0;
        repeat (6) @(negedge clk_i);
        check($sformatf("data_rd clear @%h+%0d", base, off), data_rd_o, 1'b0);
    endtask
    task automatic spi_wr(input logic [15:0] base, input logic [7:0] d);
        spi_begin();
        wr_byte(base, 2'd0, d);
        spi_end();
    endtask
    task automatic spi_rd(input logic [15:0] base, input int n);
        spi_begin();
        for (int i = 0; i < n; i++) rd_byte(base, 2'(i));
        spi_end();
    endtask
    task automatic spi_wr_rand(input int n);
        spi_begin();
        for (int i = 0; i < n; i++) wr_byte(16'h0024, 2'(i), 8'($urandom));
        spi_end();
    endtask
    task automatic core_send(input logic [7:0] d);
        int w = 0;
        while (!rsp_ready_o && w < 20) begin
            @(negedge clk_i);
            w++;
        end
        check("rsp_ready", rsp_ready_o, 1'b1);
        rsp_data_i = d;
        rsp_valid_i = 1'b1;
        @(negedge clk_i);
        rsp_valid_i = 1'b0;
        if (ms == M_EXEC && rsp_m.size() < DEPTH) rsp_m.push_back(d);
    endtask
    task automatic core_done();
        @(negedge clk_i);
        rsp_done_i = 1'b1;
        @(negedge clk_i);
        rsp_done_i = 1'b0;
        if (ms == M_EXEC) ms = M_COMPL;
    endtask
    task automatic dispatch_and_drain();
        int w = 0;
        logic [7:0] g;
        got_cmd.delete();
        spi_wr(16'h0018, 8'h20);
        repeat (3) @(negedge clk_i);
        check("cmd_go count", go_seen, exp_go);
        check("cmd_valid held", cmd_valid_o, exp_cmd.size() > 0);
        @(posedge clk_i);
        #1 cmd_ready_i = 1'b1;
        while (got_cmd.size() < exp_cmd.size() && w < 400) begin
            @(negedge clk_i);
            w++;
        end
        repeat (3) @(negedge clk_i);
        check("cmd stream length", got_cmd.size(), exp_cmd.size());
        for (int i = 0; i < exp_cmd.size(); i++) begin
            g = (i < got_cmd.size()) ? got_cmd[i] : 8'hxx;
            check($sformatf("cmd byte %0d", i), g, exp_cmd[i]);
        end
        check("cmd_valid drained", cmd_valid_o, 1'b0);
        @(posedge clk_i);
        #1 cmd_ready_i = 1'b0;
    endtask
    initial begin
        int n, m, w;
        repeat (3) @(negedge clk_i);
        check("reset rdata", rdata_o, 8'hFF);
        check("reset data_rd", data_rd_o, 1'b0);
        check("reset wr_done", wr_done_o, 1'b0);
        check("reset cmd_valid", cmd_valid_o, 1'b0);
        check("reset cmd_go", cmd_go_o, 1'b0);
        check("reset rsp_ready", rsp_ready_o, 1'b0);
        rst_n_i = 1'b1;
        repeat (3) @(negedge clk_i);
        spi_rd(16'h0000, 1);
        spi_wr(16'h0000, 8'h02);
        spi_rd(16'h0000, 1);
        spi_rd(16'h0018, 1);
        spi_wr(16'h0018, 8'h40);
        spi_rd(16'h0018, 1);
        n = $urandom_range(3, 10);
        spi_wr_rand(n);
        spi_rd(16'h0018, 4);
        dispatch_and_drain();
        spi_rd(16'h0018, 4);
        spi_wr(16'h0018, 8'h40);
        spi_wr(16'h0018, 8'h20);
        spi_rd(16'h0018, 1);
        m = $urandom_range(2, 6);
        for (int i = 0; i < m; i++) core_send(8'($urandom));
        core_done();
        spi_rd(16'h0018, 4);
        spi_rd(16'h0024, m + 1);
        spi_rd(16'h0018, 3);
        core_done();
        spi_rd(16'h0018, 1);
        spi_wr(16'h0018, 8'h40);
        core_done();
        spi_wr(16'h0018, 8'h20);
        repeat (3) @(negedge clk_i);
        check("go ignored in READY", go_seen, exp_go);
        spi_rd(16'h0018, 1);
        spi_rd(16'h0F00, 4);
        spi_rd(16'h0F04, 1);
        spi_rd(16'h0100, 1);
        spi_rd(16'h1018, 1);
        spi_wr(16'h1024, 8'h5A);
        spi_rd(16'h0018, 3);
        spi_wr_rand(DEPTH + 2);
        spi_rd(16'h0018, 4);
        dispatch_and_drain();
        spi_begin();
        addr_i = 16'h0018;
        data_req_i = 1'b1;
        w = 0;
        while (!data_rd_o && w < 12) begin
            @(negedge clk_i);
            w++;
        end
        check("data_rd before reset", data_rd_o, 1'b1);
        rst_n_i = 1'b0;
        #1;
        check("midreset rdata", rdata_o, 8'hFF);
        check("midreset data_rd", data_rd_o, 1'b0);
        check("midreset wr_done", wr_done_o, 1'b0);
        check("midreset cmd_valid", cmd_valid_o, 1'b0);
        check("midreset cmd_go", cmd_go_o, 1'b0);
        check("midreset rsp_ready", rsp_ready_o, 1'b0);
        data_req_i = 1'b0;
        spi_cs_n_i = 1'b1;
        ms = M_IDLE;
        cmd_m.delete();
        rsp_m.delete();
`ifdef TPM_ACCESS_ARB_EN
        loc_m = 1'b0;
`endif
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (3) @(negedge clk_i);
        spi_rd(16'h0018, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
